// File: rtl/div_share_if.sv
// Request/response bundle between the DIV/MOD issue paths and the shared divider.
// Each requester owns one bit of the valid/ready vectors and one DATA_W lane of the operand buses.
interface div_share_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 64
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_is_mod;
    logic [NUM_REQ-1:0]        req_is_32;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_data;

    modport master (
        output req_valid, req_a, req_b, req_is_mod, req_is_32, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_is_mod, req_is_32, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin shared radix-2 restoring divider for eBPF DIV/MOD (unsigned,
// ALU32 zero-extension, divide-by-zero gives 0 for DIV and the dividend for MOD).
module div_share_ctrl #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    div_share_if.slave bus,
    output logic       busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] LO32 = DATA_W'(64'hFFFF_FFFF);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   owner_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  q_q;
    logic [DATA_W-1:0]  rem_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mod_q;
    logic [NUM_REQ-1:0] rsp_valid_q;

    logic [IDX_W-1:0]   win;
    logic               win_vld;
    int                 rr_idx;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic               sel_mod;
    logic               sel_32;
    logic [DATA_W-1:0]  eff_a;
    logic [DATA_W-1:0]  eff_b;
    logic [DATA_W:0]    rem_sh;
    logic               ge;
    logic [DATA_W-1:0]  rem_d;
    logic [DATA_W-1:0]  q_d;

    // Scan starts one past the last winner so every waiting requester
    // is reached within NUM_REQ grants.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        rr_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (int'(last_q) + k) % NUM_REQ;
            if (!win_vld && bus.req_valid[rr_idx]) begin
                win_vld = 1'b1;
                win     = IDX_W'(rr_idx);
            end
        end
    end

    assign sel_a   = bus.req_a[int'(win)*DATA_W +: DATA_W];
    assign sel_b   = bus.req_b[int'(win)*DATA_W +: DATA_W];
    assign sel_mod = bus.req_is_mod[win];
    assign sel_32  = bus.req_is_32[win];
    assign eff_a   = sel_32 ? (sel_a & LO32) : sel_a;
    assign eff_b   = sel_32 ? (sel_b & LO32) : sel_b;

    assign bus.req_ready = (rst_n && state_q == IDLE && win_vld)
                         ? (NUM_REQ'(1) << win) : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q != IDLE);

    // One restoring step; rem_q < b_q always, so the shifted value fits DATA_W+1 bits.
    always_comb begin
        rem_sh = {rem_q, a_q[cnt_q]};
        ge     = (rem_sh >= {1'b0, b_q});
        rem_d  = ge ? DATA_W'(rem_sh - {1'b0, b_q}) : rem_sh[DATA_W-1:0];
        q_d    = q_q;
        q_d[cnt_q] = ge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            q_q         <= '0;
            rem_q       <= '0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
            mod_q       <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        owner_q <= win;
                        last_q  <= win;
                        a_q     <= eff_a;
                        b_q     <= eff_b;
                        mod_q   <= sel_mod;
                        q_q     <= '0;
                        rem_q   <= '0;
                        cnt_q   <= sel_32 ? CNT_W'(31) : CNT_W'(DATA_W - 1);
                        if (eff_b == '0) begin
                            rsp_data_q  <= sel_mod ? eff_a : '0;
                            rsp_valid_q <= NUM_REQ'(1) << win;
                            state_q     <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        rsp_data_q  <= mod_q ? rem_d : q_d;
                        rsp_valid_q <= NUM_REQ'(1) << owner_q;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (|(bus.rsp_ready & rsp_valid_q)) begin
                        rsp_valid_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl: expected results and latencies are queued
// at acceptance and compared when the response appears.
module tb_div_share_ctrl;
    localparam int N = 2;
    localparam int W = 64;
    localparam logic [W-1:0] M32 = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    div_share_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    div_share_ctrl #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         owner;
        logic [W-1:0] data;
        int         lat;
        int         t_acc;
    } exp_t;

    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   m_last = N - 1;
    int   w_m;
    bit   seen = 1'b0;
    exp_t e_m;
    exp_t sb[$];
    int   grants[$];
    logic [W-1:0] prev_data;
    logic [N-1:0] prev_vld;

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_div(logic [W-1:0] a, logic [W-1:0] b,
                                             bit m, bit s);
        if (s) begin
            a = a & M32;
            b = b & M32;
        end
        if (b == 0) return m ? a : '0;
        return m ? (a % b) : (a / b);
    endfunction

    function automatic int lat_of(logic [W-1:0] b, bit s);
        logic [W-1:0] bb;
        bb = s ? (b & M32) : b;
        if (bb == 0) return 1;
        return s ? 33 : 65;
    endfunction

    function automatic int rr_pick(logic [N-1:0] v, int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            seen   = 1'b0;
            m_last = N - 1;
        end else begin
            if (!busy) begin
                if (bus.req_valid != '0) begin
                    w_m = rr_pick(bus.req_valid, m_last);
                    check("grant", bus.req_ready, N'(1) << w_m);
                    if ((bus.req_valid & bus.req_ready) != '0) begin
                        e_m.owner = w_m;
                        e_m.data  = ref_div(bus.req_a[w_m*W +: W], bus.req_b[w_m*W +: W],
                                            bus.req_is_mod[w_m], bus.req_is_32[w_m]);
                        e_m.lat   = lat_of(bus.req_b[w_m*W +: W], bus.req_is_32[w_m]);
                        e_m.t_acc = cyc;
                        sb.push_back(e_m);
                        grants.push_back(w_m);
                        m_last = w_m;
                        acc_cnt++;
                    end
                end
            end else begin
                check("rdy_busy", bus.req_ready, '0);
            end
            if (bus.rsp_valid != '0) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        check("stale_rsp", bus.rsp_valid, '0);
                    end else begin
                        check("owner", bus.rsp_valid, N'(1) << sb[0].owner);
                        check("data", bus.rsp_data, sb[0].data);
                        check("latency", cyc - sb[0].t_acc, sb[0].lat);
                    end
                    seen = 1'b1;
                end else begin
                    check("hold_data", bus.rsp_data, prev_data);
                    check("hold_vld", bus.rsp_valid, prev_vld);
                end
                prev_data = bus.rsp_data;
                prev_vld  = bus.rsp_valid;
                if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic set_op(int r, logic [W-1:0] a, logic [W-1:0] b, bit m, bit s);
        bus.req_a[r*W +: W] = a;
        bus.req_b[r*W +: W] = b;
        bus.req_is_mod[r]   = m;
        bus.req_is_32[r]    = s;
    endtask

    task automatic issue(int r, logic [W-1:0] a, logic [W-1:0] b, bit m, bit s);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        set_op(r, a, b, m, s);
        bus.req_valid[r] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.req_ready[r]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_to", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid[r] = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (sb.size() != 0) begin
            check("rsp_to", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic op(int r, logic [W-1:0] a, logic [W-1:0] b, bit m, bit s);
        issue(r, a, b, m, s);
        drain();
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_is_mod = '0;
        bus.req_is_32  = '0;
        bus.rsp_ready  = '1;

        bus.req_valid = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.req_ready, '0);
        check("rst_valid", bus.rsp_valid, '0);
        check("rst_data", bus.rsp_data, '0);
        check("rst_busy", busy, '0);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        op(0, 64'd100, 64'd7, 1'b0, 1'b0);
        op(0, 64'd100, 64'd7, 1'b1, 1'b0);
        op(0, 64'hFFFF_FFFF_0000_0010, 64'hAAAA_AAAA_0000_0003, 1'b0, 1'b1);
        op(0, 64'hFFFF_FFFF_0000_0010, 64'hAAAA_AAAA_0000_0003, 1'b1, 1'b1);
        op(0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b0);
        op(0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b1, 1'b0);
        op(0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b1, 1'b1);
        op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        op(1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        op(1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        op(1, 64'd1000, 64'd33, 1'b1, 1'b0);

        // Backpressure on owner 0 with the non-owner's ready held high
        bus.rsp_ready = 2'b10;
        issue(0, 64'd999, 64'd10, 1'b0, 1'b1);
        for (int i = 0; i < 100 && bus.rsp_valid == '0; i++) @(negedge clk);
        check("bp_valid", bus.rsp_valid, 2'b01);
        set_op(1, 64'd77, 64'd5, 1'b1, 1'b0);
        bus.req_valid[1] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_busy", busy, 1'b1);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 2'b11;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle", busy, 1'b0);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        drain();

        // Both requesters held from reset: grants must alternate
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        set_op(0, 64'd1000, 64'd7, 1'b0, 1'b1);
        set_op(1, 64'd1000, 64'd7, 1'b1, 1'b1);
        bus.req_valid = 2'b11;
        grants.delete();
        acc_cnt = 0;
        @(negedge clk);
        check("rr_rst_ready", bus.req_ready, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 400 && acc_cnt < 4; i++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        drain();
        check("rr_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            check("rr_seq", 64'(grants[i]), 64'(i % 2));
        end

        // Reset twenty cycles into CALC drops the operation silently
        issue(0, 64'hDEAD_BEEF_0000_1234, 64'd17, 1'b0, 1'b0);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_ready", bus.req_ready, '0);
        check("mid_valid", bus.rsp_valid, '0);
        check("mid_data", bus.rsp_data, '0);
        check("mid_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_no_rsp", bus.rsp_valid, '0);
        op(0, 64'd500, 64'd9, 1'b1, 1'b0);
        op(1, 64'hFEDC_BA98_7654_3210, 64'h0000_0001_0000_0003, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("end_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Sequencing controller for the eBPF core's DIV/MOD execution.
- Owns one radix-2 restoring divider (one quotient bit per cycle) and shares it between NUM_REQ requesters, for example the ALU64 and ALU32 issue paths, using round-robin arbitration.
- Applies eBPF semantics: unsigned operation, 32-bit mode, divide-by-zero results.
- Replaces the single-cycle combinational divide on the critical path.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- DATA_W, 64, operand and result width; 32-bit mode always uses the low 32 bits.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot; high for the requester accepted this cycle.
- req_a  in  NUM_REQ*DATA_W  dividends, packed, requester i at [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  divisors, packed.
- req_is_mod  in  NUM_REQ  1 = remainder, 0 = quotient.
- req_is_32  in  NUM_REQ  1 = ALU32 operation.
- rsp_valid  out  NUM_REQ  one-hot; result available for the owning requester.
- rsp_ready  in  NUM_REQ  per-requester result acceptance.
- rsp_data  out  DATA_W  shared result bus; meaningful only while some rsp_valid bit is high.
- busy  out  1  high in any state other than IDLE.

Behaviour:

Reset:
- Asserting rst_n low asynchronously clears all state and returns the FSM to IDLE.
- req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
- Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset in CALC or DONE drops the in-flight operation; no response is ever issued for it.

States: IDLE, CALC, DONE.

IDLE:
- req_ready is combinational.
- Winner = first i with req_valid[i], scanning from (last_grant+1) mod NUM_REQ upward with wrap.
- req_ready[winner]=1 in the same cycle; a transfer occurs when req_valid & req_ready.
- On a transfer:
  - latch a, b, is_mod, is_32 and the owner index;
  - set last_grant=winner;
  - in 32-bit mode zero-extend a[31:0] and b[31:0];
  - if the effective b==0, go to DONE with result = 0 for DIV, or effective a for MOD;
  - otherwise set bit counter = W-1 (W=32 or 64), remainder=0, and go to CALC.
- req_ready is 0 in every state except IDLE.

CALC, one iteration per cycle:
- rem' = {rem, a[cnt]}.
- If rem' >= b: rem = rem' - b and q[cnt]=1; else rem = rem' and q[cnt]=0.
- Remainder datapath is DATA_W+1 bits wide.
- When cnt==0, latch the result (q or rem, zero-extended in 32-bit mode) into rsp_data and go to DONE.
- Exactly W cycles are spent in CALC.

DONE:
- rsp_valid[owner]=1 and rsp_data is held stable until rsp_ready[owner]=1.
- On that handshake: rsp_valid=0 and return to IDLE.
- rsp_ready bits of non-owners are ignored.
- No new request is accepted in the handshake cycle; the earliest next acceptance is the following cycle.

Latency:
- Request accepted in cycle T with b!=0: rsp_valid rises at T+W+1, i.e. T+65 (64-bit) or T+33 (32-bit).
- b==0: rsp_valid rises at T+1.
- Throughput is one operation per W+2 cycles, given rsp_ready is already high.

Other rules:
- Operands are registered at acceptance; later changes to req_* do not affect an in-flight operation.
- Simultaneous requests are resolved strictly by the round-robin pointer; a requester holding req_valid is served within NUM_REQ grants.
- No overflow case exists because the operation is unsigned.

Test Plan:
- Req0, a=100, b=7, DIV, 64-bit -> rsp_data=14, rsp_valid[0] exactly 65 cycles after the accept cycle; same operands with MOD -> 2.
- Req0, a=0xFFFF_FFFF_0000_0010, b=0xAAAA_AAAA_0000_0003, is_32=1, DIV -> 5 after 33 cycles; MOD -> 1.
- Divide by zero, 64-bit, a=0x1234_5678_9ABC_DEF0, b=0:
  - DIV -> 0 at T+1;
  - MOD -> a at T+1;
  - 32-bit MOD -> 0x9ABC_DEF0.
- Req0 and req1 held valid continuously from reset -> grants alternate 0,1,0,1; each response reaches only the correct owner's rsp_valid bit.
- Backpressure: rsp_ready[owner]=0 for 10 cycles in DONE -> rsp_valid and rsp_data stable, req_ready all 0, busy=1; release -> IDLE next cycle.
- Reset in mid-CALC (cycle 20 of 64) -> all outputs 0 immediately; a new request after reset completes correctly with no stale response.
- Corner case: a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> quotient all ones; b=0xFFFF_FFFF_FFFF_FFFF, a=b-1 -> DIV 0, MOD a.
